rr_arbiter_8: RTL and testbench

Eight-requester round-robin arbiter producing a registered 3-bit grant index plus a valid flag. It sits directly upstream of `decoder_3to8`: `gnt_idx` drives the decoder's `a` input, and the decoder's `y` (gated by `gnt_valid`) becomes the one-hot grant bus. It provides fair, lock-holding access to a shared resource among 8 clients.

---
 rtl/arb_pkg.sv | 9 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_arbiter_8.sv | 97 +++++++++
 tb/tb_rr_arbiter_8.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the 8-way round-robin arbiter.
package arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set req bit at or after ptr (mod 8), optionally skipping excl_idx.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             excl_en,
  input  logic [IDX_W-1:0] excl_idx,
  output logic             found,
  output logic [IDX_W-1:0] win_idx
);

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    w_idx   = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_idx = IDX_W'(ptr + IDX_W'(i));
      if (!found && req[w_idx] && !(excl_en && (w_idx == excl_idx))) begin
        found   = 1'b1;
        win_idx = w_idx;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-requester lock-holding round-robin arbiter with registered grant index/valid.
// Optional hold limit (HOLD_MAX cycles per owner) enabled by defining RR_ARB_HOLD_LIMIT_EN.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_range
    $error("rr_arbiter_8: HOLD_MAX must be in 1..255");
  end

  arb_state_t       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic             w_found;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_excl_en;
  logic             w_limit;
  logic             w_release;

  // In GRANT the current owner is never a candidate for its own handover.
  assign w_excl_en = (r_state == ARB_GRANT);
  assign w_release = !req[gnt_idx] || w_limit;

  rr_pick u_pick (
    .req      (req),
    .ptr      (r_ptr),
    .excl_en  (w_excl_en),
    .excl_idx (gnt_idx),
    .found    (w_found),
    .win_idx  (w_win_idx)
  );

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0] r_hold_cnt;

  assign w_limit = (r_hold_cnt == HOLD_LAST);

  // Counts cycles held beyond the first; any grant, switch or keep restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= 8'd0;
    end else if (r_state == ARB_GRANT && !w_release) begin
      r_hold_cnt <= 8'(r_hold_cnt + 8'd1);
    end else begin
      r_hold_cnt <= 8'd0;
    end
  end
`else
  assign w_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ARB_IDLE;
      r_ptr     <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_found) begin
            gnt_idx   <= w_win_idx;
            gnt_valid <= 1'b1;
            r_ptr     <= IDX_W'(w_win_idx + IDX_W'(1));
            r_state   <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          // No contender on release: a dropped owner goes idle, a limited owner keeps the grant.
          if (w_release) begin
            if (w_found) begin
              gnt_idx <= w_win_idx;
              r_ptr   <= IDX_W'(w_win_idx + IDX_W'(1));
            end else if (!req[gnt_idx]) begin
              gnt_valid <= 1'b0;
              r_state   <= ARB_IDLE;
            end
          end
        end
        default: begin
          r_state   <= ARB_IDLE;
          gnt_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8; covers both builds of RR_ARB_HOLD_LIMIT_EN.
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int n_cmp;
  int n_bad;

  rr_arbiter_8 #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    req   = 8'h00;
    #12;
    check("reset_valid", int'(gnt_valid), 0);
    check("reset_idx", int'(gnt_idx), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 5; c++) begin
      step();
      check("idle_valid", int'(gnt_valid), 0);
      check("idle_idx", int'(gnt_idx), 0);
    end

    req = 8'h24;
    step();
    check("h24_idx", int'(gnt_idx), 2);
    check("h24_valid", int'(gnt_valid), 1);
    req = 8'h20;
    step();
    check("drop2_idx", int'(gnt_idx), 5);
    check("drop2_valid", int'(gnt_valid), 1);
    req = 8'h00;
    step();
    check("dropall_valid", int'(gnt_valid), 0);
    check("dropall_idx_kept", int'(gnt_idx), 5);

    // Pointer is 6 now: 7 wins over 1, then 1 after wrap.
    req = 8'h82;
    step();
    check("wrap_first", int'(gnt_idx), 7);
    req = 8'h02;
    step();
    check("wrap_second", int'(gnt_idx), 1);
    req = 8'h00;
    step();
    check("wrap_idle", int'(gnt_valid), 0);

`ifdef RR_ARB_HOLD_LIMIT_EN
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check("ff_rotate_idx", int'(gnt_idx), k % 8);
        check("ff_rotate_valid", int'(gnt_valid), 1);
      end
    end
    req = 8'h08;
    for (int c = 0; c < 20; c++) begin
      step();
      check("solo_idx", int'(gnt_idx), 3);
      check("solo_valid", int'(gnt_valid), 1);
    end
`else
    do_reset();
    req = 8'h03;
    for (int c = 0; c < 30; c++) begin
      step();
      check("lock_idx", int'(gnt_idx), 0);
      check("lock_valid", int'(gnt_valid), 1);
    end
    req = 8'h02;
    step();
    check("lock_handover", int'(gnt_idx), 1);
`endif

    // Owner drop and new request on the same edge hand over directly.
    do_reset();
    req = 8'h01;
    step();
    check("simul_first", int'(gnt_idx), 0);
    req = 8'h40;
    step();
    check("simul_handover", int'(gnt_idx), 6);
    check("simul_valid", int'(gnt_valid), 1);

    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(gnt_valid), 0);
    check("midrst_idx", int'(gnt_idx), 0);
    req = 8'h41;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst_idx", int'(gnt_idx), 0);
    check("postrst_valid", int'(gnt_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
